// File: rtl/if_fetch_if.sv
// Fetch-stage bus: hazard/redirect controls from the pipeline, the IROM
// address/data pair, and the IF/ID-facing instruction outputs.
interface if_fetch_if #(
  parameter int ADDR_W = 14
);
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] irom_addr;
  logic [31:0]       irom_rdata;
  logic [31:0]       IF_inst;
  logic [31:0]       IF_pc;
  logic [31:0]       IF_pc4;
  logic              IF_valid;
  logic [31:0]       fetch_cnt;

  // Fetch stage side
  modport master (
    input  stall, redirect, redirect_pc, irom_rdata,
    output irom_addr, IF_inst, IF_pc, IF_pc4, IF_valid, fetch_cnt
  );

  // Pipeline / IROM side
  modport slave (
    output stall, redirect, redirect_pc, irom_rdata,
    input  irom_addr, IF_inst, IF_pc, IF_pc4, IF_valid, fetch_cnt
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives a synchronous-read IROM,
// holds the presented instruction across stalls and inserts one bubble on
// redirect. Counts instructions accepted by IF/ID.
// Note: the bus interface must be instantiated with the same ADDR_W.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 14
) (
  input logic         clk,
  input logic         rst_n,   // asynchronous, active-high
  if_fetch_if.master  bus
);
  localparam logic [31:0] PC0 = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0] pc_req;      // address currently on the IROM
  logic [31:0] resp_pc;     // PC of the data on irom_rdata
  logic        resp_valid;
  logic [31:0] hold_inst;   // instruction captured on stall entry
  logic        hold_v;
  logic [31:0] cnt;

  // PC / response / hold state; redirect beats stall beats advance
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc_req     <= PC0;
      resp_pc    <= '0;
      resp_valid <= 1'b0;
      hold_inst  <= '0;
      hold_v     <= 1'b0;
    end else if (bus.redirect) begin
      // data returning next cycle is wrong-path: drop it
      pc_req     <= bus.redirect_pc & 32'hFFFF_FFFC;
      resp_valid <= 1'b0;
      hold_v     <= 1'b0;
    end else if (bus.stall) begin
      // ROM keeps reading pc_req, so park the presented word once
      if (resp_valid && !hold_v) begin
        hold_inst <= bus.irom_rdata;
        hold_v    <= 1'b1;
      end
    end else begin
      resp_pc    <= pc_req;
      resp_valid <= 1'b1;
      pc_req     <= pc_req + 32'd4;
      hold_v     <= 1'b0;
    end
  end

  // Delivered-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      cnt <= '0;
    else if (resp_valid && !bus.stall && !bus.redirect)
      cnt <= cnt + 32'd1;
  end

  assign bus.irom_addr = pc_req[ADDR_W+1:2];
  assign bus.IF_valid  = resp_valid;
  assign bus.IF_inst   = !resp_valid ? 32'd0 : (hold_v ? hold_inst : bus.irom_rdata);
  assign bus.IF_pc     = resp_valid ? resp_pc : 32'd0;
  assign bus.IF_pc4    = resp_valid ? resp_pc + 32'd4 : 32'd0;
  assign bus.fetch_cnt = cnt;
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a per-cycle vector table (inputs driven in
// that cycle, outputs expected in that cycle) plus an async mid-stall reset.
module tb_if_fetch;
  localparam int ADDR_W = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  if_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  if_fetch #(.RESET_PC(32'h0000_0100), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous IROM: word k holds 0x1000 + k
  always @(posedge clk) bus.irom_rdata <= 32'h1000 + {18'd0, bus.irom_addr};

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [31:0] eaddr;
    logic [31:0] ecnt;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, " valid"}, {31'd0, bus.IF_valid}, {31'd0, v.ev});
    chk({tag, " pc"},    bus.IF_pc, v.epc);
    chk({tag, " inst"},  bus.IF_inst, v.einst);
    chk({tag, " pc4"},   bus.IF_pc4, v.ev ? v.epc + 32'd4 : 32'd0);
    chk({tag, " addr"},  {18'd0, bus.irom_addr}, v.eaddr);
    chk({tag, " cnt"},   bus.fetch_cnt, v.ecnt);
  endtask

  // Starts at a negedge: check this cycle, drive its inputs, move on
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      chk_outs($sformatf("row%0d", i), tbl[i]);
      bus.stall       = tbl[i].stall;
      bus.redirect    = tbl[i].redir;
      bus.redirect_pc = tbl[i].rpc;
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t rst_exp;
    //            stall redir rpc            ev epc            einst          eaddr          ecnt
    tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,    32'h40,   32'd0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h100,       32'h1040, 32'h41,   32'd0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h104,       32'h1041, 32'h42,   32'd1};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h104,       32'h1041, 32'h42,   32'd1};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h104,       32'h1041, 32'h42,   32'd1};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h104,       32'h1041, 32'h42,   32'd1};
    tbl[6]  = '{1'b0, 1'b1, 32'h202,       1'b1, 32'h108,       32'h1042, 32'h43,   32'd2};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,    32'h80,   32'd2};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h200,       32'h1080, 32'h81,   32'd2};
    tbl[9]  = '{1'b1, 1'b1, 32'h300,       1'b1, 32'h200,       32'h1080, 32'h81,   32'd2};
    tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,    32'hC0,   32'd2};
    tbl[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h300,       32'h10C0, 32'hC1,   32'd2};
    tbl[12] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h304,       32'h10C1, 32'hC2,   32'd3};
    tbl[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,    32'h3FFF, 32'd3};
    tbl[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h4FFF, 32'h0,    32'd3};
    tbl[15] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h1000, 32'h1,    32'd4};
    tbl[16] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         32'h1001, 32'h2,    32'd5};
    tbl[17] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         32'h1001, 32'h2,    32'd5};
    // restart after the mid-stall reset: plain sequential fetch
    tbl[18] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,    32'h40,   32'd0};
    tbl[19] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h100,       32'h1040, 32'h41,   32'd0};
    tbl[20] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h104,       32'h1041, 32'h42,   32'd1};
    tbl[21] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h108,       32'h1042, 32'h43,   32'd2};
    tbl[22] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h10C,       32'h1043, 32'h44,   32'd3};
    tbl[23] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h110,       32'h1044, 32'h45,   32'd4};

    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    run_rows(0, 17);

    // Async reset while a stalled instruction is held
    #2 rst_n = 1'b1;
    #1;
    rst_exp = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h40, 32'd0};
    chk_outs("midrst", rst_exp);
    @(negedge clk);
    rst_n     = 1'b0;
    bus.stall = 1'b0;
    run_rows(18, 23);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
